propose_move_controller: RTL and testbench
==========================================

PROPOSE_MOVE_CONTROLLER -- requirements
Module: propose_move_controller

Interface
REQ-001 Parameter MAXIMUM_BIT_WIDTH_OF_COEFFICIENT, default 8, coefficient/bias width W.
REQ-002 Parameter MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX, default 2, variable index width V; N=2**V variables.
REQ-003 Parameter MAX_BIT_WIDTH_OF_CLAUSES_INDEX, default 3, clause index width C; K=2**C clause slots.
REQ-004 Parameter PROPOSE_LATENCY, default 2, cycles from reduce-enable issue to datapath result valid; legal range 1..15.
REQ-005 in_clk  input  1  sole clock; all logic on rising edge.
REQ-006 in_reset  input  1  synchronous, active-high reset.
REQ-007 in_load_valid  input  1  host offers one clause.
REQ-008 in_load_coefficients  input  (N+1)*W  clause coefficients plus bias.
REQ-009 out_load_ready  output  1  controller accepts a clause this cycle.
REQ-010 in_clear_clauses  input  1  discard all loaded clauses.
REQ-011 in_start  input  1  request one corner-point proposal.
REQ-012 in_variable_index  input  V  variable to be moved.
REQ-013 out_clause_coefficients  output  (N+1)*W  coefficients to clause registers.
REQ-014 out_clause_index  output  C  target clause slot.
REQ-015 out_clause_write  output  1  one-cycle write strobe for the slot.
REQ-016 out_reduce_enable  output  K  per-clause reduce enables.
REQ-017 out_variable_index  output  V  held variable index to datapath.
REQ-018 in_new_assignment  input  W  signed datapath result.
REQ-019 out_new_value  output  W  signed captured proposal.
REQ-020 out_done  output  1  one-cycle completion pulse.
REQ-021 out_error  output  1  valid with out_done; proposal not performed.
REQ-022 out_busy  output  1  high in any state other than IDLE.
REQ-023 out_num_clauses  output  C+1  number of loaded clauses, 0..K.

Function
REQ-024 States SHALL be IDLE, ISSUE, WAIT, DONE; load handling occurs only in IDLE.
REQ-025 out_load_ready SHALL be 1 only in IDLE with in_clear_clauses=0, in_start=0 and out_num_clauses<K.
REQ-026 On accept (valid&ready) the block SHALL register coefficients and write pointer onto out_clause_coefficients/out_clause_index and pulse out_clause_write the next cycle, then increment pointer and out_num_clauses.
REQ-027 out_clause_index and out_clause_coefficients SHALL hold last values when out_clause_write=0.
REQ-028 Loads beyond K SHALL be refused (ready low); count saturates at K, no wrap.
REQ-029 in_clear_clauses in IDLE SHALL zero pointer and count next cycle; it has priority over load and start in the same cycle.
REQ-030 in_start in IDLE with count>0 SHALL latch in_variable_index to out_variable_index and go to ISSUE; start has priority over load in the same cycle.
REQ-031 in_start in IDLE with count=0 SHALL produce out_done=1, out_error=1 next cycle, out_new_value unchanged, state stays IDLE.
REQ-032 ISSUE SHALL last one cycle with out_reduce_enable bit i = (i < out_num_clauses), all bits 0 in every other state.
REQ-033 WAIT SHALL last exactly PROPOSE_LATENCY cycles via a down-counter.
REQ-034 DONE SHALL last one cycle: capture in_new_assignment into out_new_value, out_done=1, out_error=0, then IDLE.
REQ-035 Latency: start accepted in cycle 0 -> ISSUE cycle 1 -> out_done in cycle PROPOSE_LATENCY+2.
REQ-036 in_start, in_load_valid and in_clear_clauses outside IDLE SHALL be ignored; out_variable_index stable until next accepted start.

Reset
REQ-037 In a reset cycle: state IDLE, pointer 0, out_num_clauses 0, out_clause_write 0, out_reduce_enable 0, out_done 0, out_error 0, out_busy 0, out_new_value 0, out_clause_index 0, out_clause_coefficients 0, out_variable_index 0.
REQ-038 Reset mid-operation SHALL abort any proposal with no out_done pulse and discard loaded clauses.

Verification
REQ-039 Load 3 clauses back-to-back -> write strobes to slots 0,1,2 on consecutive cycles, out_num_clauses=3.
REQ-040 3 loaded, start var 2, result 8'sd5, default latency -> out_reduce_enable=8'b00000111 in cycle 1, out_done with out_new_value=5 in cycle 4.
REQ-041 Start with 0 clauses -> out_done=1, out_error=1 next cycle, no reduce enable.
REQ-042 Load 8 clauses, offer 9th -> out_load_ready=0, count stays 8; start -> enable 8'hFF.
REQ-043 Start and clear same cycle -> cleared, no proposal; start, load, clear during WAIT -> ignored, done unaffected.
REQ-044 Reset asserted in WAIT -> no out_done, out_num_clauses=0, out_busy=0 next cycle.

Source files
------------

// File: rtl/propose_move_controller.sv
// Sequencer for one corner-point proposal: loads clause coefficients into
// clause slots, fires the per-clause reduce enables and captures the result.
module propose_move_controller #(
    parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 8,
    parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 2,
    parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 3,
    parameter int PROPOSE_LATENCY                     = 2
) (
    input  logic                                                                  in_clk,
    input  logic                                                                  in_reset,
    input  logic                                                                  in_load_valid,
    input  logic [(2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_load_coefficients,
    output logic                                                                  out_load_ready,
    input  logic                                                                  in_clear_clauses,
    input  logic                                                                  in_start,
    input  logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0]                        in_variable_index,
    output logic [(2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] out_clause_coefficients,
    output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0]                             out_clause_index,
    output logic                                                                  out_clause_write,
    output logic [2**MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0]                          out_reduce_enable,
    output logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0]                        out_variable_index,
    input  logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0]                    in_new_assignment,
    output logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0]                    out_new_value,
    output logic                                                                  out_done,
    output logic                                                                  out_error,
    output logic                                                                  out_busy,
    output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0]                               out_num_clauses
);

    localparam int W  = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
    localparam int V  = MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX;
    localparam int C  = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int N  = 2 ** V;
    localparam int K  = 2 ** C;
    localparam int CW = (N + 1) * W;

    localparam logic [C:0] K_COUNT = (C + 1)'(K);
    localparam logic [3:0] LAT     = 4'(PROPOSE_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t       state;
    logic [C-1:0] wr_ptr;
    logic [3:0]   wait_cnt;

    // Only the first `count` clause slots hold valid clauses.
    function automatic logic [K-1:0] enable_mask(input logic [C:0] count);
        logic [K-1:0] mask;
        mask = '0;
        for (int i = 0; i < K; i++) begin
            mask[i] = ((C + 1)'(i) < count);
        end
        return mask;
    endfunction

    assign out_load_ready = (state == S_IDLE) && !in_clear_clauses && !in_start &&
                            (out_num_clauses < K_COUNT);

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state                   <= S_IDLE;
            wr_ptr                  <= '0;
            wait_cnt                <= '0;
            out_num_clauses         <= '0;
            out_clause_write        <= 1'b0;
            out_reduce_enable       <= '0;
            out_done                <= 1'b0;
            out_error               <= 1'b0;
            out_busy                <= 1'b0;
            out_new_value           <= '0;
            out_clause_index        <= '0;
            out_clause_coefficients <= '0;
            out_variable_index      <= '0;
        end else begin
            out_clause_write  <= 1'b0;
            out_done          <= 1'b0;
            out_error         <= 1'b0;
            out_reduce_enable <= '0;

            case (state)
                S_IDLE: begin
                    if (in_clear_clauses) begin
                        wr_ptr          <= '0;
                        out_num_clauses <= '0;
                    end else if (in_start) begin
                        if (out_num_clauses == '0) begin
                            out_done  <= 1'b1;
                            out_error <= 1'b1;
                        end else begin
                            out_variable_index <= in_variable_index;
                            out_reduce_enable  <= enable_mask(out_num_clauses);
                            out_busy           <= 1'b1;
                            state              <= S_ISSUE;
                        end
                    end else if (in_load_valid && out_load_ready) begin
                        out_clause_coefficients <= in_load_coefficients;
                        out_clause_index        <= wr_ptr;
                        out_clause_write        <= 1'b1;
                        wr_ptr                  <= wr_ptr + C'(1);
                        out_num_clauses         <= out_num_clauses + (C + 1)'(1);
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= LAT;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Last wait cycle is the one where the datapath result is valid.
                    if (wait_cnt <= 4'd1) begin
                        out_new_value <= in_new_assignment;
                        out_done      <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    out_busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    out_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    logic unused_width;
    assign unused_width = ^{CW[0]};

endmodule

// File: tb/tb_propose_move_controller.sv
// Randomized scoreboard bench for propose_move_controller with a transaction-level model.
module tb_propose_move_controller;

    localparam int L = 2;
    localparam int K = 8;

    logic        clk = 1'b0;
    logic        in_reset = 1'b1;
    logic        in_load_valid = 1'b0;
    logic [39:0] in_load_coefficients = '0;
    logic        out_load_ready;
    logic        in_clear_clauses = 1'b0;
    logic        in_start = 1'b0;
    logic [1:0]  in_variable_index = '0;
    logic [39:0] out_clause_coefficients;
    logic [2:0]  out_clause_index;
    logic        out_clause_write;
    logic [7:0]  out_reduce_enable;
    logic [1:0]  out_variable_index;
    logic signed [7:0] dp_result;
    logic signed [7:0] out_new_value;
    logic        out_done;
    logic        out_error;
    logic        out_busy;
    logic [3:0]  out_num_clauses;

    propose_move_controller #(
        .MAXIMUM_BIT_WIDTH_OF_COEFFICIENT(8),
        .MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX(2),
        .MAX_BIT_WIDTH_OF_CLAUSES_INDEX(3),
        .PROPOSE_LATENCY(L)
    ) dut (
        .in_clk(clk),
        .in_reset(in_reset),
        .in_load_valid(in_load_valid),
        .in_load_coefficients(in_load_coefficients),
        .out_load_ready(out_load_ready),
        .in_clear_clauses(in_clear_clauses),
        .in_start(in_start),
        .in_variable_index(in_variable_index),
        .out_clause_coefficients(out_clause_coefficients),
        .out_clause_index(out_clause_index),
        .out_clause_write(out_clause_write),
        .out_reduce_enable(out_reduce_enable),
        .out_variable_index(out_variable_index),
        .in_new_assignment(dp_result),
        .out_new_value(out_new_value),
        .out_done(out_done),
        .out_error(out_error),
        .out_busy(out_busy),
        .out_num_clauses(out_num_clauses)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: a distinct value every cycle so capture timing is visible.
    function automatic logic [7:0] dp_val(input int c);
        return 8'(c * 37 + 11);
    endfunction
    assign dp_result = dp_val(cyc);

    typedef struct { int cyc; int idx; logic [39:0] cf; } wr_t;
    typedef struct { int cyc; logic [7:0] mask; logic [1:0] vi; } en_t;
    typedef struct { int cyc; logic err; logic [7:0] val; } done_t;

    wr_t   wr_q[$];
    en_t   en_q[$];
    done_t done_q[$];

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    // Reference state: clauses held as a list; slot of a new clause is its position.
    logic [39:0] clauses[$];
    logic [7:0]  last_val = '0;
    int          idle_from = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_clause_write === 1'b1) begin
                if (wr_q.size() == 0) flag("write_unexpected");
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(w.cyc));
                    chk("write_slot", 64'(out_clause_index), 64'(w.idx));
                    chk("write_coefs", 64'(out_clause_coefficients), 64'(w.cf));
                end
            end
            if (out_reduce_enable !== 8'd0) begin
                if (en_q.size() == 0) flag("enable_unexpected");
                else begin
                    en_t e;
                    e = en_q.pop_front();
                    chk("enable_cycle", 64'(cyc), 64'(e.cyc));
                    chk("enable_mask", 64'(out_reduce_enable), 64'(e.mask));
                    chk("variable_index", 64'(out_variable_index), 64'(e.vi));
                end
            end
            if (out_done === 1'b1) begin
                if (done_q.size() == 0) flag("done_unexpected");
                else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(d.cyc));
                    chk("done_error", 64'(out_error), 64'(d.err));
                    chk("new_value", 64'($unsigned(out_new_value)), 64'(d.val));
                end
            end else if (out_error === 1'b1) begin
                flag("error_without_done");
            end
        end
    end

    task automatic model_reset(input int n);
        while (wr_q.size() > 0 && wr_q[$].cyc > n) void'(wr_q.pop_back());
        while (en_q.size() > 0 && en_q[$].cyc > n) void'(en_q.pop_back());
        while (done_q.size() > 0 && done_q[$].cyc > n) void'(done_q.pop_back());
        clauses.delete();
        last_val  = '0;
        idle_from = n + 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        in_reset = 1'b1; in_start = 1'b0; in_load_valid = 1'b0; in_clear_clauses = 1'b0;
        model_reset(cyc);
    endtask

    task automatic step(input logic st, input logic ld, input logic clr,
                        input logic [1:0] vi, input logic [39:0] cf);
        int  n;
        bit  idle;
        int  cnt;
        @(posedge clk); #1;
        in_reset = 1'b0; in_start = st; in_load_valid = ld; in_clear_clauses = clr;
        in_variable_index = vi; in_load_coefficients = cf;
        #1;
        n    = cyc;
        idle = (n >= idle_from);
        cnt  = clauses.size();
        chk("busy", 64'(out_busy), 64'(!idle));
        chk("num_clauses", 64'(out_num_clauses), 64'(cnt));
        chk("load_ready", 64'(out_load_ready), 64'(idle && !clr && !st && cnt < K));
        if (idle) begin
            if (clr) begin
                clauses.delete();
            end else if (st) begin
                if (cnt == 0) begin
                    done_q.push_back('{cyc: n + 1, err: 1'b1, val: last_val});
                end else begin
                    en_q.push_back('{cyc: n + 1, mask: 8'((1 << cnt) - 1), vi: vi});
                    last_val = dp_val(n + L + 1);
                    done_q.push_back('{cyc: n + L + 2, err: 1'b0, val: last_val});
                    idle_from = n + L + 3;
                end
            end else if (ld && cnt < K) begin
                wr_q.push_back('{cyc: n + 1, idx: cnt, cf: cf});
                clauses.push_back(cf);
            end
        end
    endtask

    function automatic logic [39:0] rnd_cf();
        return {8'($urandom), 32'($urandom)};
    endfunction

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 2'd0, '0);
    endtask

    initial begin
        do_reset();
        do_reset();
        @(posedge clk); #2;
        model_reset(cyc);
        chk("rst_busy", 64'(out_busy), 64'd0);
        chk("rst_num", 64'(out_num_clauses), 64'd0);
        chk("rst_write", 64'(out_clause_write), 64'd0);
        chk("rst_enable", 64'(out_reduce_enable), 64'd0);
        chk("rst_done", 64'(out_done), 64'd0);
        chk("rst_error", 64'(out_error), 64'd0);
        chk("rst_value", 64'($unsigned(out_new_value)), 64'd0);
        chk("rst_index", 64'(out_clause_index), 64'd0);
        chk("rst_coefs", 64'(out_clause_coefficients), 64'd0);
        chk("rst_var", 64'(out_variable_index), 64'd0);
        mon_en = 1'b1;

        // Start with no clauses, then three back-to-back loads and a proposal.
        step(1'b1, 1'b0, 1'b0, 2'd1, '0);
        idle_steps(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd0, rnd_cf());
        step(1'b1, 1'b0, 1'b0, 2'd2, '0);
        step(1'b1, 1'b1, 1'b1, 2'd3, rnd_cf());
        step(1'b1, 1'b1, 1'b1, 2'd1, rnd_cf());
        idle_steps(3);

        // Start and clear together, then fill all slots and offer one more.
        step(1'b1, 1'b0, 1'b1, 2'd1, '0);
        idle_steps(1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 2'd0, rnd_cf());
        step(1'b1, 1'b0, 1'b0, 2'd3, '0);
        idle_steps(L + 3);

        // Reset while waiting on the datapath.
        step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        idle_steps(2);
        do_reset();
        idle_steps(3);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) do_reset();
            else step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 15) == 0, 2'($urandom), rnd_cf());
        end
        idle_steps(L + 5);

        chk("pending_writes", 64'(wr_q.size()), 64'd0);
        chk("pending_enables", 64'(en_q.size()), 64'd0);
        chk("pending_dones", 64'(done_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
